// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: command codes, FSM encoding and
// default widths.
package alu_defs;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultTagW  = 4;
  localparam int unsigned CntWidth     = 2;

  typedef enum logic [2:0] {
    CmdAdd  = 3'd0,
    CmdSub  = 3'd1,
    CmdXor  = 3'd2,
    CmdSlt  = 3'd3,
    CmdAnd  = 3'd4,
    CmdNand = 3'd5,
    CmdNor  = 3'd6,
    CmdOr   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and response channels between an operation driver (master) and the
// sequencer (slave).
interface alu_op_sequencer_if
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned TAG_W = DefaultTagW
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_cmd;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carryout;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_cmd, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_tag
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_tag
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Serialises ALU operations: holds operands on the ALU inputs, waits ALU_LATENCY cycles,
// captures result and flags and returns them with the request tag.
module alu_op_sequencer
  import alu_defs::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned ALU_LATENCY = 0,
  parameter int unsigned TAG_W       = DefaultTagW
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0]  alu_operand_a,
  output logic [WIDTH-1:0]  alu_operand_b,
  output logic [2:0]        alu_command,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_carryout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam logic [CntWidth-1:0] LatInit = CntWidth'(ALU_LATENCY);

  seq_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d;
  logic [WIDTH-1:0]    op_b_q, op_b_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic [TAG_W-1:0]    rtag_q, rtag_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic [15:0]         op_count_q, op_count_d;
  logic                req_ready;
  logic                accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    res_d      = res_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    rtag_d     = rtag_q;
    op_count_d = op_count_q;
    req_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
      end
      StExec: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          carry_d = alu_carryout;
          zero_d  = alu_zero;
          ovf_d   = alu_overflow;
          rtag_d  = tag_q;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        // Ready follows the consumer so a new op can start on the completing edge.
        req_ready = bus.rsp_ready;
        if (bus.rsp_ready) begin
          op_count_d = sat_inc16(op_count_q);
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    accept = req_ready && bus.req_valid;
    if (accept) begin
      op_a_d  = bus.req_a;
      op_b_d  = bus.req_b;
      cmd_d   = bus.req_cmd;
      tag_d   = bus.req_tag;
      cnt_d   = LatInit;
      state_d = StExec;
    end

    rsp_valid_d = (state_d == StResp);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cmd_q       <= '0;
      tag_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rtag_q      <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      rtag_q      <= rtag_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_carryout = carry_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_tag      = rtag_q;

  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_command   = cmd_q;
  assign busy          = busy_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Two sequencers (ALU latency 0 and 2), each paired with a behavioural ALU, driven by
// directed steps; responses are checked against a per-instance expectation queue.
module tb_alu_op_sequencer;
  import alu_defs::*;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, rsp_ready, req_ready, rsp_valid;
  logic [1:0]  rsp_carryout, rsp_zero, rsp_overflow, busy;
  logic [2:0]  req_cmd [2];
  logic [2:0]  alu_command [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [31:0] rsp_result [2];
  logic [31:0] alu_operand_a [2];
  logic [31:0] alu_operand_b [2];
  logic [3:0]  req_tag [2];
  logic [3:0]  rsp_tag [2];
  logic [15:0] op_count [2];

  int   cyc = 0;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   n_rsp [2] = '{0, 0};
  int   last_rsp_cyc [2] = '{0, 0};
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] alu_f(input logic [2:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        o;
    s = '0;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (cmd)
      CmdAdd: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      CmdSub: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      CmdXor:  r = a ^ b;
      CmdSlt:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      CmdAnd:  r = a & b;
      CmdNand: r = ~(a & b);
      CmdNor:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, o, (r == 32'd0), r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = 2 * g;
    alu_op_sequencer_if #(.WIDTH(32), .TAG_W(4)) sif ();
    logic [31:0] alu_result;
    logic        alu_carryout, alu_zero, alu_overflow;
    logic [34:0] alu_now, pipe0, pipe1, alu_out;

    assign sif.req_valid = req_valid[g];
    assign sif.req_cmd   = req_cmd[g];
    assign sif.req_a     = req_a[g];
    assign sif.req_b     = req_b[g];
    assign sif.req_tag   = req_tag[g];
    assign sif.rsp_ready = rsp_ready[g];
    assign req_ready[g]    = sif.req_ready;
    assign rsp_valid[g]    = sif.rsp_valid;
    assign rsp_result[g]   = sif.rsp_result;
    assign rsp_carryout[g] = sif.rsp_carryout;
    assign rsp_zero[g]     = sif.rsp_zero;
    assign rsp_overflow[g] = sif.rsp_overflow;
    assign rsp_tag[g]      = sif.rsp_tag;

    // Pipelined ALU: output reflects the operands presented Lat cycles earlier.
    assign alu_now = alu_f(alu_command[g], alu_operand_a[g], alu_operand_b[g]);
    always @(posedge clk) begin
      pipe0 <= alu_now;
      pipe1 <= pipe0;
    end
    assign alu_out = (Lat == 0) ? alu_now : pipe1;
    assign {alu_carryout, alu_overflow, alu_zero, alu_result} = alu_out;

    alu_op_sequencer #(.WIDTH(32), .ALU_LATENCY(Lat), .TAG_W(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (sif.slave),
      .alu_operand_a(alu_operand_a[g]),
      .alu_operand_b(alu_operand_b[g]),
      .alu_command  (alu_command[g]),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .busy         (busy[g]),
      .op_count     (op_count[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic void push(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  // Scoreboard: every completed response handshake pops and checks one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] && rsp_ready[d]) begin
        int   pend;
        exp_t e;
        pend = (d == 0) ? exp_q0.size() : exp_q1.size();
        n_rsp[d]++;
        last_rsp_cyc[d] = cyc;
        chk("rsp_expected", 64'(pend > 0), 1);
        if (pend > 0) begin
          if (d == 0) e = exp_q0.pop_front();
          else e = exp_q1.pop_front();
          chk("rsp_tag", rsp_tag[d], e.tag);
          chk("rsp_result", rsp_result[d], e.r);
          chk("rsp_carryout", rsp_carryout[d], e.c);
          chk("rsp_zero", rsp_zero[d], e.z);
          chk("rsp_overflow", rsp_overflow[d], e.o);
        end
      end
    end
  end

  task automatic drive(input int d, input logic [2:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    req_cmd[d]   = cmd;
    req_a[d]     = a;
    req_b[d]     = b;
    req_tag[d]   = tag;
    req_valid[d] = 1'b1;
  endtask

  // Returns the cycle number whose closing edge accepted the request.
  task automatic wait_accept(input int d, output int acc);
    bit got = 1'b0;
    acc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[d] && req_valid[d]) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    chk("accept_seen", 64'(got), 1);
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the first cycle with rsp_valid high.
  task automatic wait_valid(input int d, output int rc);
    bit got = 1'b0;
    rc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        rc = cyc;
        got = 1'b1;
        break;
      end
    end
    chk("rsp_valid_seen", 64'(got), 1);
  endtask

  task automatic chk_count(input int d, input logic [15:0] exp);
    @(negedge clk);
    chk("op_count", op_count[d], exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int d, input logic [2:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input logic [31:0] r,
                        input logic c, input logic z, input logic o);
    int acc, rc, base;
    base = n_rsp[d];
    push(d, '{tag: tag, r: r, c: c, z: z, o: o});
    drive(d, cmd, a, b, tag);
    wait_accept(d, acc);
    req_valid[d] = 1'b0;
    wait_valid(d, rc);
    chk("rsp_latency", 64'(rc - acc), 64'(2 + lat(d)));
    @(posedge clk);
    #1;
    chk("rsp_handshakes", 64'(n_rsp[d]), 64'(base + 1));
  endtask

  task automatic back_to_back(input int d);
    int acc1, acc2, base;
    base = n_rsp[d];
    rsp_ready[d] = 1'b1;
    push(d, '{tag: 4'd9, r: 32'd1, c: 1'b0, z: 1'b0, o: 1'b0});
    drive(d, CmdSlt, 32'hFFFF_FFFF, 32'h0, 4'd9);
    wait_accept(d, acc1);
    push(d, '{tag: 4'd10, r: 32'h0F0F_0F0F, c: 1'b0, z: 1'b0, o: 1'b0});
    drive(d, CmdXor, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'd10);
    wait_accept(d, acc2);
    req_valid[d] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (n_rsp[d] >= base + 2) break;
      @(posedge clk);
      #1;
    end
    // An issue period spans 3+L cycles counting both accepting cycles: edges 2+L apart.
    chk("b2b_issue_interval", 64'(acc2 - acc1), 64'(2 + lat(d)));
    chk("b2b_handshakes", 64'(n_rsp[d]), 64'(base + 2));
    chk("b2b_second_latency", 64'(last_rsp_cyc[d] - acc2), 64'(2 + lat(d)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, rc, base;
    bit seen;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_cmd[d] = '0;
      req_a[d]   = '0;
      req_b[d]   = '0;
      req_tag[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", busy[d], 0);
      chk("reset_rsp_valid", rsp_valid[d], 0);
      chk("reset_op_count", op_count[d], 0);
      chk("reset_alu_a", alu_operand_a[d], 0);
      chk("reset_rsp_tag", rsp_tag[d], 0);
      chk("reset_req_ready", req_ready[d], 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency 0: basic add and flag corners.
    rsp_ready[0] = 1'b1;
    run_op(0, CmdAdd, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0, 1'b0);
    chk_count(0, 16'd1);
    chk("idle_busy", busy[0], 0);
    run_op(0, CmdAdd, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op(0, CmdAdd, 32'h7FFF_FFFF, 32'd1, 4'd6, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    back_to_back(0);
    chk_count(0, 16'd5);

    // Latency 2: consumer stalls for 5 cycles while a new request waits.
    base = n_rsp[1];
    rsp_ready[1] = 1'b0;
    push(1, '{tag: 4'd2, r: 32'd7, c: 1'b1, z: 1'b0, o: 1'b0});
    drive(1, CmdSub, 32'd10, 32'd3, 4'd2);
    wait_accept(1, acc);
    req_valid[1] = 1'b0;
    wait_valid(1, rc);
    chk("hold_latency", 64'(rc - acc), 4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_rsp_valid", rsp_valid[1], 1);
      chk("hold_rsp_result", rsp_result[1], 32'd7);
      chk("hold_rsp_tag", rsp_tag[1], 4'd2);
      chk("hold_req_ready", req_ready[1], 0);
      chk("hold_alu_a", alu_operand_a[1], 32'd10);
      chk("hold_alu_b", alu_operand_b[1], 32'd3);
      chk("hold_alu_cmd", alu_command[1], CmdSub);
      @(posedge clk);
      #1;
      if (i == 0) begin
        push(1, '{tag: 4'd4, r: 32'hFF00_0000, c: 1'b0, z: 1'b0, o: 1'b0});
        drive(1, CmdNor, 32'h0000_FFFF, 32'h00FF_00FF, 4'd4);
      end
    end
    rsp_ready[1] = 1'b1;
    wait_accept(1, acc);
    chk("hold_release_cycle", 64'(acc - rc), 5);
    req_valid[1] = 1'b0;
    wait_valid(1, rc);
    chk("chained_latency", 64'(rc - acc), 4);
    @(posedge clk);
    #1;
    chk("hold_handshakes", 64'(n_rsp[1]), 64'(base + 2));
    chk_count(1, 16'd2);
    back_to_back(1);
    chk_count(1, 16'd4);

    // Asynchronous reset during EXEC discards the operation.
    drive(1, CmdAdd, 32'd1, 32'd2, 4'd7);
    wait_accept(1, acc);
    req_valid[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy[1], 0);
    chk("async_alu_a", alu_operand_a[1], 0);
    chk("async_alu_b", alu_operand_b[1], 0);
    chk("async_rsp_result", rsp_result[1], 0);
    chk("async_rsp_tag", rsp_tag[1], 0);
    chk("async_op_count", op_count[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    chk("no_rsp_after_reset", 64'(seen), 0);
    @(posedge clk);
    #1;
    run_op(1, CmdAdd, 32'd1, 32'd2, 4'd7, 32'd3, 1'b0, 1'b0, 1'b0);
    chk_count(1, 16'd1);

    // Saturation of the completion counter.
    force g_dut[1].u_dut.op_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release g_dut[1].u_dut.op_count_q;
    chk_count(1, 16'hFFFE);
    run_op(1, CmdOr, 32'h0F, 32'hF0, 4'd11, 32'hFF, 1'b0, 1'b0, 1'b0);
    chk_count(1, 16'hFFFF);
    run_op(1, CmdAnd, 32'hFF, 32'h0F, 4'd12, 32'h0F, 1'b0, 1'b0, 1'b0);
    chk_count(1, 16'hFFFF);

    chk("leftover_exp_lat0", 64'(exp_q0.size()), 0);
    chk("leftover_exp_lat2", 64'(exp_q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
